fp_int_mac_seq_ctrl: RTL and testbench

FP_INT_MAC_SEQ_CTRL -- requirements
Module: fp_int_mac_seq_ctrl

---
 rtl/fp_int_mac_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_fp_int_mac_seq_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_int_mac_seq_ctrl.sv
// fp_int_mac_seq_ctrl
//   Sequencer for a bit-serial FP16 x INT MAC unit. It accepts one job
//   (precision, length, alignment exponent), fetches elements through a
//   valid/ready handshake, and loads each activation into the MAC. It then
//   streams the weight LSB first, waits for the MAC to finish, and chains the
//   returned accumulator into the next element. The final accumulator and
//   exponent are presented through a valid/ready result handshake.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   start, cfg_*      job launch and configuration (sampled in IDLE only)
//   busy              high whenever a job is in progress
//   in_valid/in_ready element handshake; in_act / in_w element payload
//   mac_set           one-cycle load pulse to the MAC
//   mac_valid, mac_w  serial weight bit and its qualifier
//   mac_act           held activation
//   mac_precision     effective precision
//   mac_exp_min       latched alignment exponent
//   mac_acc           running accumulator
//   mac_done, mac_fixed_out, mac_exp_out
//                     MAC completion and results
//   res_valid/res_ready, res_acc, res_exp
//                     final result handshake
//   err_tmo           sticky MAC timeout flag, cleared on the next start
module fp_int_mac_seq_ctrl #(
  parameter int ACT_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int W_MAX     = 8,
  parameter int TMO       = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           cfg_precision,
  input  logic [7:0]           cfg_len,
  input  logic [4:0]           cfg_exp_min,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [W_MAX-1:0]     in_w,
  output logic                 mac_set,
  output logic                 mac_valid,
  output logic                 mac_w,
  output logic [ACT_WIDTH-1:0] mac_act,
  output logic [3:0]           mac_precision,
  output logic [4:0]           mac_exp_min,
  output logic [ACC_WIDTH-1:0] mac_acc,
  input  logic                 mac_done,
  input  logic [ACC_WIDTH-1:0] mac_fixed_out,
  input  logic [4:0]           mac_exp_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_WIDTH-1:0] res_acc,
  output logic [4:0]           res_exp,
  output logic                 err_tmo
);

  localparam int            BW       = (W_MAX > 1) ? $clog2(W_MAX) : 1;
  localparam int            TW       = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [3:0]    P_MAX    = 4'(W_MAX);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SET,
    SHIFT,
    WAIT,
    RESULT
  } state_t;

  state_t state_q, state_d;

  logic [3:0]           prec_q;
  logic [7:0]           len_q;
  logic [4:0]           exp_min_q;
  logic [ACT_WIDTH-1:0] act_q;
  logic [W_MAX-1:0]     w_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [4:0]           exp_q;
  logic [7:0]           cnt_q;
  logic [3:0]           bit_q;
  logic [TW-1:0]        tmo_q;
  logic                 err_q;

  logic [3:0] prec_eff;
  logic [7:0] cnt_inc;
  logic       last_bit;
  logic       tmo_hit;
  logic       last_elem;

  always_comb begin
    prec_eff = cfg_precision;
    if (cfg_precision == 4'd0 || cfg_precision > P_MAX) prec_eff = P_MAX;
  end

  assign cnt_inc   = cnt_q + 8'd1;
  assign last_bit  = (bit_q == (prec_q - 4'd1));
  assign tmo_hit   = (tmo_q == TMO_LAST);
  assign last_elem = (cnt_inc == len_q);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = (cfg_len == 8'd0) ? RESULT : FETCH;
      FETCH:  if (in_valid) state_d = SET;
      SET:    state_d = SHIFT;
      SHIFT:  if (last_bit) state_d = WAIT;
      // A timeout consumes the element exactly like a completion would.
      WAIT:   if (mac_done || tmo_hit) state_d = last_elem ? RESULT : FETCH;
      RESULT: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prec_q    <= '0;
      len_q     <= '0;
      exp_min_q <= '0;
      act_q     <= '0;
      w_q       <= '0;
      acc_q     <= '0;
      exp_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            prec_q    <= prec_eff;
            len_q     <= cfg_len;
            exp_min_q <= cfg_exp_min;
            acc_q     <= '0;
            exp_q     <= cfg_exp_min;
            cnt_q     <= '0;
            err_q     <= 1'b0;
          end
        end
        FETCH: begin
          if (in_valid) begin
            act_q <= in_act;
            w_q   <= in_w;
            bit_q <= '0;
          end
        end
        SHIFT: begin
          bit_q <= bit_q + 4'd1;
          tmo_q <= '0;
        end
        WAIT: begin
          if (mac_done) begin
            acc_q <= mac_fixed_out;
            exp_q <= mac_exp_out;
            cnt_q <= cnt_inc;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            cnt_q <= cnt_inc;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign in_ready      = (state_q == FETCH);
  assign mac_set       = (state_q == SET);
  assign mac_valid     = (state_q == SHIFT);
  assign mac_w         = (state_q == SHIFT) & w_q[bit_q[BW-1:0]];
  assign mac_act       = act_q;
  assign mac_precision = prec_q;
  assign mac_exp_min   = exp_min_q;
  assign mac_acc       = acc_q;
  assign res_valid     = (state_q == RESULT);
  assign res_acc       = acc_q;
  assign res_exp       = exp_q;
  assign err_tmo       = err_q;

endmodule

// File: tb/tb_fp_int_mac_seq_ctrl.sv
// Testbench for fp_int_mac_seq_ctrl. The bench acts as the element source,
// the MAC, and the result sink. Expected values come from a job-level model:
// clamped precision, weight bit order, chained accumulator, timeout
// accounting, and cycle latency.
module tb_fp_int_mac_seq_ctrl;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  cfg_precision;
  logic [7:0]  cfg_len;
  logic [4:0]  cfg_exp_min;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_act;
  logic [7:0]  in_w;
  logic        mac_set;
  logic        mac_valid;
  logic        mac_w;
  logic [15:0] mac_act;
  logic [3:0]  mac_precision;
  logic [4:0]  mac_exp_min;
  logic [31:0] mac_acc;
  logic        mac_done;
  logic [31:0] mac_fixed_out;
  logic [4:0]  mac_exp_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_acc;
  logic [4:0]  res_exp;
  logic        err_tmo;

  always #5 clk = ~clk;

  fp_int_mac_seq_ctrl #(.ACT_WIDTH(16), .ACC_WIDTH(32), .W_MAX(8), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_precision(cfg_precision),
    .cfg_len(cfg_len), .cfg_exp_min(cfg_exp_min), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_w(in_w),
    .mac_set(mac_set), .mac_valid(mac_valid), .mac_w(mac_w), .mac_act(mac_act),
    .mac_precision(mac_precision), .mac_exp_min(mac_exp_min), .mac_acc(mac_acc),
    .mac_done(mac_done), .mac_fixed_out(mac_fixed_out), .mac_exp_out(mac_exp_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_acc(res_acc),
    .res_exp(res_exp), .err_tmo(err_tmo)
  );

  int errors = 0;
  int checks = 0;

  // Job description. A delay d means mac_done is raised on WAIT cycle d
  // (0-based). Any d >= TMO never answers, so the element times out.
  int          j_len;
  logic [3:0]  j_prec;
  logic [4:0]  j_expmin;
  logic [15:0] j_act[16];
  logic [7:0]  j_w[16];
  logic [31:0] j_fix[16];
  logic [4:0]  j_mexp[16];
  int          j_delay[16];
  int          j_hold;
  bit          j_noise;

  // Observations gathered while a job runs. Cycle 1 is the first cycle
  // after the start edge.
  int          o_set_cnt;
  int          o_set_cycle[16];
  logic [31:0] o_acc_at_set[16];
  logic [15:0] o_act[16];
  logic [3:0]  o_prec[16];
  int          o_valid_cnt[16];
  logic [7:0]  o_bits[16];
  int          o_wait_cnt[16];
  int          o_res_cycle;
  int          o_res_len;
  logic [31:0] o_res_acc;
  logic [4:0]  o_res_exp;
  bit          o_res_unstable;
  logic        o_err_c1;
  logic        o_err_end;
  logic        o_busy_after;
  bit          o_timeout;

  function automatic int eff_prec(input logic [3:0] p);
    return (p == 4'd0 || p > 4'd8) ? 8 : int'(p);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job;
    int cyc;
    int e;
    int wc;
    bit pending;
    bit in_wait;
    bit fin;
    logic [31:0] h_acc;
    logic [4:0]  h_exp;
    for (int i = 0; i < 16; i++) begin
      o_set_cycle[i] = -1; o_acc_at_set[i] = 'x; o_act[i] = 'x; o_prec[i] = 'x;
      o_valid_cnt[i] = 0; o_bits[i] = '0; o_wait_cnt[i] = 0;
    end
    o_set_cnt = 0; o_res_cycle = -1; o_res_len = 0; o_res_unstable = 0;
    o_timeout = 0; o_err_end = 1'bx; o_busy_after = 1'bx;
    h_acc = '0; h_exp = '0;
    start = 1'b1; cfg_precision = j_prec; cfg_len = 8'(j_len); cfg_exp_min = j_expmin;
    in_valid = 1'b0; mac_done = 1'b0; res_ready = 1'b0;
    tick;
    start = 1'b0;
    o_err_c1 = err_tmo;
    cyc = 1; e = 0; wc = 0; pending = 0; fin = 0;
    while (!fin && cyc < 3000) begin
      in_wait = busy && !in_ready && !mac_set && !mac_valid && !res_valid;
      if (!in_wait && pending) begin e++; wc = 0; pending = 0; end
      in_valid = 1'b0; mac_done = 1'b0; start = 1'b0;
      if (j_noise && !in_wait) begin
        // Stray mac_done and start outside WAIT/IDLE must have no effect.
        mac_done = 1'b1; mac_fixed_out = $urandom; mac_exp_out = 5'($urandom);
        start = 1'b1; cfg_len = 8'($urandom); cfg_precision = 4'($urandom);
        cfg_exp_min = 5'($urandom);
      end
      if (in_ready && e < 16) begin
        in_valid = 1'b1; in_act = j_act[e]; in_w = j_w[e];
      end
      if (mac_set && e < 16) begin
        o_set_cnt++; o_set_cycle[e] = cyc; o_acc_at_set[e] = mac_acc;
        o_act[e] = mac_act; o_prec[e] = mac_precision;
      end
      if (mac_valid && e < 16) begin
        if (o_valid_cnt[e] < 8) o_bits[e][o_valid_cnt[e]] = mac_w;
        o_valid_cnt[e]++;
      end
      if (in_wait && e < 16) begin
        pending = 1;
        o_wait_cnt[e]++;
        if (wc == j_delay[e]) begin
          mac_done = 1'b1; mac_fixed_out = j_fix[e]; mac_exp_out = j_mexp[e];
        end
        wc++;
      end
      if (res_valid) begin
        if (o_res_len == 0) begin
          o_res_cycle = cyc; h_acc = res_acc; h_exp = res_exp; o_err_end = err_tmo;
        end else if (res_acc !== h_acc || res_exp !== h_exp) begin
          o_res_unstable = 1;
        end
        o_res_len++;
        if (o_res_len > j_hold) begin res_ready = 1'b1; fin = 1; end
      end
      tick;
      cyc++;
    end
    if (!fin) o_timeout = 1;
    else o_busy_after = busy;
    o_res_acc = h_acc; o_res_exp = h_exp;
    start = 1'b0; mac_done = 1'b0; res_ready = 1'b0; in_valid = 1'b0;
  endtask

  task automatic default_job(input int len, input logic [3:0] prec);
    j_len = len; j_prec = prec; j_expmin = 5'($urandom); j_hold = 0; j_noise = 0;
    for (int i = 0; i < 16; i++) begin
      j_act[i] = 16'($urandom); j_w[i] = 8'($urandom);
      j_fix[i] = $urandom | 32'h1; j_mexp[i] = 5'($urandom); j_delay[i] = 0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; cfg_precision = '0; cfg_len = '0; cfg_exp_min = '0;
    in_valid = 1'b0; in_act = '0; in_w = '0; mac_done = 1'b0; mac_fixed_out = '0;
    mac_exp_out = '0; res_ready = 1'b0;
    tick; tick;
    checks++;
    if ({busy, in_ready, mac_set, mac_valid, mac_w, mac_act, mac_precision, mac_exp_min,
         mac_acc, res_valid, res_acc, res_exp, err_tmo} !== '0)
      begin errors++; $display("FAIL reset_outputs: busy=%b in_ready=%b res_valid=%b mac_acc=%0h expected all zero", busy, in_ready, res_valid, mac_acc); end
    rst = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single;
    default_job(1, 4'd4);
    j_act[0] = 16'h4569; j_w[0] = 8'b0000_0101;
    run_job;
    checks++;
    if (o_timeout) begin errors++; $display("FAIL single_finish: job did not finish in budget"); end
    checks++;
    if (o_set_cycle[0] != 2) begin errors++; $display("FAIL single_set_cycle: got %0d expected 2", o_set_cycle[0]); end
    checks++;
    if (o_valid_cnt[0] != 4 || o_bits[0] !== 8'b0000_0101)
      begin errors++; $display("FAIL single_serial: got %0d bits %b expected 4 bits 00000101", o_valid_cnt[0], o_bits[0]); end
    // FETCH, SET, 4 SHIFT, 1 WAIT occupy cycles 1..7; the result follows.
    checks++;
    if (o_res_cycle != 8) begin errors++; $display("FAIL single_latency: res_valid cycle %0d expected 8", o_res_cycle); end
    checks++;
    if (o_res_acc !== j_fix[0] || o_res_exp !== j_mexp[0])
      begin errors++; $display("FAIL single_result: got %0h/%0h expected %0h/%0h", o_res_acc, o_res_exp, j_fix[0], j_mexp[0]); end
    checks++;
    if (o_act[0] !== 16'h4569 || o_prec[0] !== 4'd4 || o_acc_at_set[0] !== 32'h0)
      begin errors++; $display("FAIL single_mac_load: act=%0h prec=%0d acc=%0h expected 4569/4/0", o_act[0], o_prec[0], o_acc_at_set[0]); end
    checks++;
    if (o_busy_after !== 1'b0) begin errors++; $display("FAIL single_result_one_cycle: busy=%b expected 0", o_busy_after); end
  endtask

  task automatic test_chain;
    default_job(3, 4'd3);
    j_delay[1] = 2; j_delay[2] = 5;
    run_job;
    checks++;
    if (o_set_cnt != 3) begin errors++; $display("FAIL chain_set_count: got %0d expected 3", o_set_cnt); end
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (o_acc_at_set[n] !== ((n == 0) ? 32'h0 : j_fix[n-1]))
        begin errors++; $display("FAIL chain_acc_%0d: got %0h expected %0h", n, o_acc_at_set[n], (n == 0) ? 32'h0 : j_fix[n-1]); end
    end
    checks++;
    if (o_res_acc !== j_fix[2] || o_res_exp !== j_mexp[2])
      begin errors++; $display("FAIL chain_result: got %0h expected %0h", o_res_acc, j_fix[2]); end
  endtask

  task automatic test_clamp;
    logic [3:0] cfgs[2];
    cfgs[0] = 4'd0; cfgs[1] = 4'd12;
    for (int k = 0; k < 2; k++) begin
      default_job(2, cfgs[k]);
      run_job;
      for (int n = 0; n < 2; n++) begin
        checks++;
        if (o_valid_cnt[n] != 8 || o_prec[n] !== 4'd8 || o_bits[n] !== j_w[n])
          begin errors++; $display("FAIL clamp_cfg%0d_elem%0d: valid=%0d prec=%0d bits=%0h expected 8/8/%0h", cfgs[k], n, o_valid_cnt[n], o_prec[n], o_bits[n], j_w[n]); end
      end
    end
  endtask

  task automatic test_timeout;
    default_job(2, 4'd2);
    j_delay[1] = 1000;
    run_job;
    checks++;
    if (o_wait_cnt[1] != TMO) begin errors++; $display("FAIL tmo_wait_cycles: got %0d expected %0d", o_wait_cnt[1], TMO); end
    checks++;
    if (o_err_end !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b expected 1", o_err_end); end
    checks++;
    if (o_res_acc !== j_fix[0] || o_res_exp !== j_mexp[0])
      begin errors++; $display("FAIL tmo_acc_kept: got %0h expected %0h", o_res_acc, j_fix[0]); end
    checks++;
    if (err_tmo !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", err_tmo); end
    // mac_done on the very last WAIT cycle still counts as a completion.
    default_job(1, 4'd1);
    j_delay[0] = TMO - 1;
    run_job;
    checks++;
    if (o_err_c1 !== 1'b0) begin errors++; $display("FAIL tmo_clear_on_start: got %b expected 0", o_err_c1); end
    checks++;
    if (o_err_end !== 1'b0 || o_res_acc !== j_fix[0] || o_wait_cnt[0] != TMO)
      begin errors++; $display("FAIL tmo_last_cycle_done: err=%b acc=%0h waits=%0d expected 0/%0h/%0d", o_err_end, o_res_acc, o_wait_cnt[0], j_fix[0], TMO); end
  endtask

  task automatic test_backpressure_empty;
    default_job(1, 4'd5);
    j_hold = 5;
    run_job;
    checks++;
    if (o_res_unstable || o_res_len != 6)
      begin errors++; $display("FAIL bp_stable: unstable=%0d res_cycles=%0d expected 0/6", o_res_unstable, o_res_len); end
    checks++;
    if (o_res_acc !== j_fix[0]) begin errors++; $display("FAIL bp_result: got %0h expected %0h", o_res_acc, j_fix[0]); end
    default_job(0, 4'd3);
    run_job;
    checks++;
    if (o_res_cycle != 1 || o_set_cnt != 0)
      begin errors++; $display("FAIL empty_latency: res cycle %0d sets %0d expected 1/0", o_res_cycle, o_set_cnt); end
    checks++;
    if (o_res_acc !== 32'h0 || o_res_exp !== j_expmin)
      begin errors++; $display("FAIL empty_result: got %0h/%0h expected 0/%0h", o_res_acc, o_res_exp, j_expmin); end
  endtask

  task automatic test_mid_reset;
    int n;
    start = 1'b1; cfg_precision = 4'd5; cfg_len = 8'd2; cfg_exp_min = 5'd9;
    tick;
    start = 1'b0;
    n = 0;
    while (!mac_valid && n < 20) begin
      in_valid = in_ready; in_act = 16'h3C00; in_w = 8'hA5;
      tick;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (mac_valid !== 1'b1) begin errors++; $display("FAIL midrst_reach_shift: mac_valid=%b expected 1", mac_valid); end
    rst = 1'b0;
    tick;
    checks++;
    if ({busy, in_ready, mac_set, mac_valid, mac_w, mac_act, mac_precision, mac_exp_min,
         mac_acc, res_valid, res_acc, res_exp, err_tmo} !== '0)
      begin errors++; $display("FAIL midrst_outputs: busy=%b mac_act=%0h mac_precision=%0d mac_exp_min=%0d expected all zero", busy, mac_act, mac_precision, mac_exp_min); end
    rst = 1'b1;
    tick;
    default_job(1, 4'd6);
    run_job;
    checks++;
    if (o_timeout || o_res_acc !== j_fix[0] || o_bits[0] !== (j_w[0] & 8'h3F) || o_res_cycle != 10)
      begin errors++; $display("FAIL midrst_rerun: acc=%0h bits=%0h cycle=%0d expected %0h/%0h/10", o_res_acc, o_bits[0], o_res_cycle, j_fix[0], j_w[0] & 8'h3F); end
  endtask

  task automatic test_random;
    int p, waits, exp_cyc;
    logic [31:0] m_acc;
    logic [4:0]  m_exp;
    logic        m_err;
    logic [7:0]  mask;
    for (int job = 0; job < 8; job++) begin
      default_job(int'($urandom_range(1, 4)), 4'($urandom));
      j_noise = 1;
      j_hold = int'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++)
        j_delay[i] = ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(0, 5));
      run_job;
      p = eff_prec(j_prec);
      mask = 8'hFF >> (8 - p);
      m_acc = '0; m_exp = j_expmin; m_err = 1'b0; exp_cyc = 1;
      for (int n = 0; n < j_len; n++) begin
        checks++;
        if (o_acc_at_set[n] !== m_acc || o_act[n] !== j_act[n] || o_prec[n] !== 4'(p))
          begin errors++; $display("FAIL rnd%0d_load%0d: acc=%0h act=%0h prec=%0d expected %0h/%0h/%0d", job, n, o_acc_at_set[n], o_act[n], o_prec[n], m_acc, j_act[n], p); end
        checks++;
        if (o_valid_cnt[n] != p || o_bits[n] !== (j_w[n] & mask))
          begin errors++; $display("FAIL rnd%0d_serial%0d: cnt=%0d bits=%0h expected %0d/%0h", job, n, o_valid_cnt[n], o_bits[n], p, j_w[n] & mask); end
        waits = (j_delay[n] < TMO) ? j_delay[n] + 1 : TMO;
        checks++;
        if (o_wait_cnt[n] != waits)
          begin errors++; $display("FAIL rnd%0d_wait%0d: got %0d expected %0d", job, n, o_wait_cnt[n], waits); end
        exp_cyc += 2 + p + waits;
        if (j_delay[n] < TMO) begin m_acc = j_fix[n]; m_exp = j_mexp[n]; end
        else m_err = 1'b1;
      end
      checks++;
      if (o_timeout || o_res_cycle != exp_cyc || o_set_cnt != j_len)
        begin errors++; $display("FAIL rnd%0d_timing: res cycle %0d sets %0d expected %0d/%0d", job, o_res_cycle, o_set_cnt, exp_cyc, j_len); end
      checks++;
      if (o_res_acc !== m_acc || o_res_exp !== m_exp || o_err_end !== m_err || o_res_unstable)
        begin errors++; $display("FAIL rnd%0d_result: acc=%0h exp=%0h err=%b expected %0h/%0h/%b", job, o_res_acc, o_res_exp, o_err_end, m_acc, m_exp, m_err); end
      checks++;
      if (o_busy_after !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle: busy=%b expected 0", job, o_busy_after); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_chain;
    test_clamp;
    test_timeout;
    test_backpressure_empty;
    test_mid_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
